// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT datapath (dct_stage1 output side and
// the block reader that consumes it).
package dct_pkg;

  localparam int DCT_DIM    = 8;
  localparam int DCT_ELEM_W = 11;

  typedef logic signed [DCT_ELEM_W-1:0] dct_elem_t;
  typedef dct_elem_t [DCT_DIM-1:0]      dct_col_t;
  typedef dct_col_t  [DCT_DIM-1:0]      dct_block_t;

  typedef enum logic {
    IDLE,
    STREAM
  } rdr_state_e;

endpackage

// File: rtl/dct_block_buf.sv
// One 8x8 block register with a capture enable and a column-select read mux.
// Reading column col_sel returns element [r][col_sel] for every row r.
module dct_block_buf #(
  parameter int SIZE_IN = 11,
  parameter int DIM     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [DIM-1:0][DIM-1:0][SIZE_IN-1:0] block_in,
  input  logic [2:0]                        col_sel,
  output logic [DIM-1:0][SIZE_IN-1:0]       col_out
);

  logic [DIM-1:0][DIM-1:0][SIZE_IN-1:0] mem;

  // Block storage: cleared on reset, overwritten whole on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (load) begin
      mem <= block_in;
    end
  end

  // Transposed read: pick one column across all rows.
  always_comb begin
    col_out = '0;
    for (int unsigned r = 0; r < DIM; r++) begin
      col_out[r] = mem[r][col_sel];
    end
  end

endmodule

// File: rtl/dct_block_reader.sv
// Block reader: captures an 8x8 row-transform block on block_valid and streams
// it out column by column with a valid/ready handshake.
// Optional macro DCT_READER_DBUF_EN adds a shadow buffer so a block arriving
// mid-stream is held and follows the current one with no bubble.
module dct_block_reader
  import dct_pkg::*;
#(
  parameter int SIZE_IN = 11,
  parameter int DIM     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DIM-1:0][DIM-1:0][SIZE_IN-1:0] block_in,
  input  logic                                 block_valid,
  output logic [DIM-1:0][SIZE_IN-1:0]          col_out,
  output logic                                 col_valid,
  input  logic                                 col_ready,
  output logic [2:0]                           col_idx,
  output logic                                 col_last,
  output logic                                 busy,
  output logic                                 overrun
);

  rdr_state_e state, state_nxt;
  logic [2:0] idx_nxt;
  logic       ovr_nxt;
  logic       load_act;
  logic       accept;
  logic       last_acc;
  logic [DIM-1:0][SIZE_IN-1:0] out0;

  assign col_valid = (state == STREAM);
  assign accept    = col_valid & col_ready;
  assign last_acc  = accept & (col_idx == 3'd7);
  assign col_last  = col_valid & (col_idx == 3'd7);

`ifdef DCT_READER_DBUF_EN
  logic rd_sel, sel_nxt;
  logic shadow_full, shf_nxt;
  logic load_shd;
  logic [DIM-1:0][SIZE_IN-1:0] out1;

  assign busy    = col_valid | shadow_full;
  assign col_out = rd_sel ? out1 : out0;

  // rd_sel marks the streaming buffer; the other one is the shadow.
  dct_block_buf #(.SIZE_IN(SIZE_IN), .DIM(DIM)) u_buf0 (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_sel ? load_shd : load_act),
    .block_in (block_in),
    .col_sel  (col_idx),
    .col_out  (out0)
  );

  dct_block_buf #(.SIZE_IN(SIZE_IN), .DIM(DIM)) u_buf1 (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_sel ? load_act : load_shd),
    .block_in (block_in),
    .col_sel  (col_idx),
    .col_out  (out1)
  );
`else
  assign busy    = col_valid;
  assign col_out = out0;

  dct_block_buf #(.SIZE_IN(SIZE_IN), .DIM(DIM)) u_buf0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load_act),
    .block_in (block_in),
    .col_sel  (col_idx),
    .col_out  (out0)
  );
`endif

  // State, column counter and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col_idx     <= '0;
      overrun     <= 1'b0;
`ifdef DCT_READER_DBUF_EN
      rd_sel      <= 1'b0;
      shadow_full <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      col_idx     <= idx_nxt;
      overrun     <= ovr_nxt;
`ifdef DCT_READER_DBUF_EN
      rd_sel      <= sel_nxt;
      shadow_full <= shf_nxt;
`endif
    end
  end

  // Next-state, capture enables and overrun detection.
  always_comb begin
    state_nxt = state;
    idx_nxt   = col_idx;
    ovr_nxt   = overrun;
    load_act  = 1'b0;
`ifdef DCT_READER_DBUF_EN
    load_shd  = 1'b0;
    sel_nxt   = rd_sel;
    shf_nxt   = shadow_full;
`endif
    case (state)
      IDLE: begin
        if (block_valid) begin
          load_act  = 1'b1;
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (last_acc) begin
          idx_nxt = '0;
`ifdef DCT_READER_DBUF_EN
          // On a swap the outgoing buffer is fully consumed this cycle, so a
          // simultaneous new block is written into it as the next shadow.
          if (shadow_full) begin
            sel_nxt  = ~rd_sel;
            load_act = block_valid;
            shf_nxt  = block_valid;
          end else if (block_valid) begin
            load_act = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
`else
          if (block_valid) begin
            load_act = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
`endif
        end else begin
          if (accept) begin
            idx_nxt = col_idx + 3'd1;
          end
          if (block_valid) begin
`ifdef DCT_READER_DBUF_EN
            if (!shadow_full) begin
              load_shd = 1'b1;
              shf_nxt  = 1'b1;
            end else begin
              ovr_nxt = 1'b1;
            end
`else
            ovr_nxt = 1'b1;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
